// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared defines for the register file, decode and writeback stages
package register_file_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;

    localparam logic [DATA_WIDTH-1:0]    ZERO_WORD             = '0;
    localparam logic [ADDRESS_WIDTH-1:0] REGISTER_ADDRESS_ZERO = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one read port: reset/enable/r0 gating and optional WB->ID bypass
// Optional feature: REGISTER_FILE_BYPASS_EN selects write_data on a same-cycle write hit.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH    = register_file_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = register_file_pkg::ADDRESS_WIDTH
) (
    input  logic                     reset,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    storage_data,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data
);

`ifdef REGISTER_FILE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = (write_enable == ENABLE) && (write_address == read_address);
`else
    logic bypass_hit;
    logic unused_write_side;
    assign bypass_hit        = DISABLE;
    assign unused_write_side = ^{write_enable, write_address, write_data};
`endif

    // Priority order matters: r0 must win over a bypass hit on address 0.
    always_comb begin
        read_data = ZERO_WORD;
        if (reset) begin
            read_data = ZERO_WORD;
        end else if (read_enable != ENABLE) begin
            read_data = ZERO_WORD;
        end else if (read_address == REGISTER_ADDRESS_ZERO) begin
            read_data = ZERO_WORD;
        end else if (bypass_hit) begin
            read_data = write_data;
        end else begin
            read_data = storage_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS GPR file, two combinational read ports, one write port
// Optional feature: REGISTER_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH     = register_file_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = register_file_pkg::ADDRESS_WIDTH,
    parameter int REGISTER_COUNT = 2 ** ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_enable_1,
    input  logic [ADDRESS_WIDTH-1:0] read_address_1,
    output logic [DATA_WIDTH-1:0]    read_data_1,
    input  logic                     read_enable_2,
    input  logic [ADDRESS_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0]    read_data_2
);

    // Deliberately not reset: system benches expect unwritten entries to stay unknown.
    logic [DATA_WIDTH-1:0] storage [0:REGISTER_COUNT-1];

    always_ff @(posedge clock) begin
        if (!reset && write_enable && (write_address != REGISTER_ADDRESS_ZERO)) begin
            storage[write_address] <= write_data;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_read_port_1 (
        .reset         (reset),
        .read_enable   (read_enable_1),
        .read_address  (read_address_1),
        .storage_data  (storage[read_address_1]),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data_1)
    );

    register_file_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_read_port_2 (
        .reset         (reset),
        .read_enable   (read_enable_2),
        .read_address  (read_address_2),
        .storage_data  (storage[read_address_2]),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data_2)
    );

endmodule
